phase_clock_gen: RTL and testbench
==================================

# phase_clock_gen

Programmable N-phase non-overlapping clock generator, the parametrised successor to the fixed two-phase divide-by-2 clock divider. From one input clock it produces NUM_PHASES phase enables that fire in round-robin order, each high for a programmable slot length and separated by a programmable dead gap. It drives the multi-phase sequencing of the processor datapath and replaces the hard-wired complementary clk1/clk2 pair.

## Interface
- NUM_PHASES, default 2: number of output phases; legal range 2..16.
- CNT_W, default 8: width of the slot-length and gap-length counters and inputs.
- clkIn  input  1  system clock; all logic is on its rising edge.
- rstN  input  1  reset, synchronous, active-low.
- enable  input  1  run request, sampled each edge.
- slotLen  input  CNT_W  cycles each phase stays high; 0 is treated as 1.
- gapLen  input  CNT_W  all-low dead cycles after each phase; 0 means no gap.
- phaseOut  output  NUM_PHASES  one-hot-or-zero phase signals, registered.
- roundStrobe  output  1  one-cycle pulse on the first cycle of phase 0.
- running  output  1  high while a round is in progress.

## Operation
- States: IDLE, SLOT, GAP.
- Reset, with rstN low at an edge, forces the following values: state IDLE, phaseOut=0, roundStrobe=0, running=0, phase index 0, counter 0.
- **IDLE**
  - enable=1 at an edge moves the block to SLOT with phase index 0.
  - slotLen and gapLen are latched into shadow registers L and G. 0 is mapped to 1 for L only.
  - phaseOut[0]=1, roundStrobe=1 and running=1 from that edge.
- **SLOT**
  - phaseOut[idx] stays high for exactly L cycles.
  - If G>0, the block then enters GAP with phaseOut=0 for exactly G cycles.
  - If G=0, it moves directly to the next phase slot, so phases are back-to-back but never overlap.
- **Next phase**
  - idx increments after each slot/gap pair.
  - After phase NUM_PHASES-1 the index wraps to 0 (round boundary).
- **Round boundary**
  - If enable=1, the block re-latches slotLen/gapLen and starts phase 0 with a roundStrobe pulse.
  - If enable=0, it returns to IDLE with all outputs 0.
- Configuration is taken only at a round boundary. Mid-round changes to slotLen/gapLen have no effect until the next round.
- When enable deasserts mid-round, the current round completes in full. Phases are never truncated.
- Invariants:
  - At most one phaseOut bit is high in any cycle.
  - Each phase is high for exactly L consecutive cycles.
  - Every output comes straight from a flop, so there are no combinational glitches.
- Round period is NUM_PHASES*(L+G) input cycles.

## Timing
- Latency: enable sampled high at edge k in IDLE gives phaseOut[0]=1 visible after edge k.
- Back-to-back rounds: phase 0 of the next round starts on the edge immediately after the last cycle of the previous round's final slot or gap. There is no idle bubble.
- The slot/gap counter is CNT_W bits and counts from L-1 (or G-1) down to 0. There is no wrap or overflow: the maximum L is 2^CNT_W-1.
- A mid-operation reset (rstN low at any edge) takes effect at that edge with the reset values above. The first edge with rstN high is treated as IDLE.
- If enable and rstN are both low/high in conflict at the same edge, reset wins.
- running drops on the same edge at which phaseOut returns to 0 on entry to IDLE.

## Structure
- A shared package, phase_clock_pkg, holds:
  - the state enum typedef (IDLE/SLOT/GAP);
  - the localparam for the NUM_PHASES legal maximum;
  - the phase-index width function, ceil(log2(NUM_PHASES)).
- One natural sub-module, phase_slot_counter: a loadable CNT_W down-counter with a terminal-count flag, used for both SLOT and GAP.
- The top level holds the FSM, the phase index, the shadow L/G registers and the one-hot decode register.

## Test plan
- **Legacy equivalence:** NUM_PHASES=2, slotLen=1, gapLen=0, enable held 1 → phaseOut toggles 01,10,01,... each cycle; roundStrobe every 2 cycles.
- **Non-overlap:** NUM_PHASES=4, slotLen=3, gapLen=2 → each bit high 3 cycles, then 2 all-zero cycles, order 0,1,2,3; period 20 cycles; check popcount(phaseOut)≤1 every cycle.
- **Zero slot:** slotLen=0, gapLen=0 behaves identically to slotLen=1.
- **Mid-round reconfig:** change slotLen 2→5 during phase 1 → the current round keeps 2-cycle slots; the next round's phase 0 lasts 5 cycles.
- **Enable drop:** deassert enable in phase 0's slot (NUM_PHASES=3, L=2, G=1) → the round finishes after 9 cycles from its start, then phaseOut=0, running=0, no roundStrobe.
- **Reset mid-slot:** assert rstN=0 for one edge during phase 2 → all outputs 0 that edge; re-enable restarts at phase 0 with roundStrobe.

Source files
------------

// File: rtl/phase_clock_pkg.sv
// Shared types and helpers for the N-phase non-overlapping clock generator.
package phase_clock_pkg;

  localparam int MAX_PHASES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_GAP  = 2'd2
  } phase_state_e;

  // Width of the phase index; at least one bit even for two phases.
  function automatic int phase_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_slot_counter.sv
// Loadable down-counter timing one slot or gap; tc_o flags the last cycle.
// Load has priority; otherwise counts down and holds at zero.
module phase_slot_counter
  import phase_clock_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/phase_clock_gen.sv
// Programmable N-phase non-overlapping clock generator: round-robin phase
// enables of L cycles each, separated by G dead cycles, all outputs registered.
module phase_clock_gen
  import phase_clock_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clkIn,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      slotLen,
  input  logic [CNT_W-1:0]      gapLen,
  output logic [NUM_PHASES-1:0] phaseOut,
  output logic                  roundStrobe,
  output logic                  running
);

  localparam int IDX_W = phase_idx_w(NUM_PHASES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PHASE0   = NUM_PHASES'(1);

  phase_state_e          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  strobe_q, strobe_d;
  logic                  running_q, running_d;
  logic [CNT_W-1:0]      l_q, l_d;
  logic [CNT_W-1:0]      g_q, g_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             start_round;
  logic             next_phase;
  logic [CNT_W-1:0] l_new;

  assign l_new = (slotLen == '0) ? CNT_W'(1) : slotLen;

  phase_slot_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clkIn),
    .rst_n_i    (rstN),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    strobe_d    = 1'b0;
    running_d   = running_q;
    l_d         = l_q;
    g_d         = g_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    start_round = 1'b0;
    next_phase  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) start_round = 1'b1;
      end
      ST_SLOT: begin
        if (cnt_tc) begin
          if (g_q != '0) begin
            state_d  = ST_GAP;
            phase_d  = '0;
            cnt_load = 1'b1;
            cnt_val  = g_q - CNT_W'(1);
          end else begin
            next_phase = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt_tc) next_phase = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Round boundary: enable is only consulted after the last phase finishes.
    if (next_phase) begin
      if (idx_q == LAST_IDX) begin
        if (enable) begin
          start_round = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          phase_d   = '0;
          running_d = 1'b0;
        end
      end else begin
        state_d  = ST_SLOT;
        idx_d    = idx_q + IDX_W'(1);
        phase_d  = PHASE0 << idx_d;
        cnt_load = 1'b1;
        cnt_val  = l_q - CNT_W'(1);
      end
    end

    if (start_round) begin
      state_d   = ST_SLOT;
      idx_d     = '0;
      phase_d   = PHASE0;
      strobe_d  = 1'b1;
      running_d = 1'b1;
      l_d       = l_new;
      g_d       = gapLen;
      cnt_load  = 1'b1;
      cnt_val   = l_new - CNT_W'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      phase_q   <= '0;
      strobe_q  <= 1'b0;
      running_q <= 1'b0;
      l_q       <= CNT_W'(1);
      g_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      strobe_q  <= strobe_d;
      running_q <= running_d;
      l_q       <= l_d;
      g_q       <= g_d;
    end
  end

  assign phaseOut    = phase_q;
  assign roundStrobe = strobe_q;
  assign running     = running_q;

endmodule

// File: tb/tb_phase_clock_gen.sv
// Directed bench for phase_clock_gen at 2, 3 and 4 phases.
module tb_phase_clock_gen;

  logic       clkIn = 1'b0;
  logic       rstN = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] slotLen = 8'd1;
  logic [7:0] gapLen = 8'd0;

  logic [1:0] ph2;
  logic [2:0] ph3;
  logic [3:0] ph4;
  logic       st2, st3, st4;
  logic       run2, run3, run4;

  int total = 0;
  int bad   = 0;

  always #5 clkIn = ~clkIn;

  phase_clock_gen #(.NUM_PHASES(2), .CNT_W(8)) dut2 (
    .clkIn(clkIn), .rstN(rstN), .enable(enable), .slotLen(slotLen), .gapLen(gapLen),
    .phaseOut(ph2), .roundStrobe(st2), .running(run2));
  phase_clock_gen #(.NUM_PHASES(3), .CNT_W(8)) dut3 (
    .clkIn(clkIn), .rstN(rstN), .enable(enable), .slotLen(slotLen), .gapLen(gapLen),
    .phaseOut(ph3), .roundStrobe(st3), .running(run3));
  phase_clock_gen #(.NUM_PHASES(4), .CNT_W(8)) dut4 (
    .clkIn(clkIn), .rstN(rstN), .enable(enable), .slotLen(slotLen), .gapLen(gapLen),
    .phaseOut(ph4), .roundStrobe(st4), .running(run4));

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] sl;
    logic [7:0] gl;
    logic [1:0] ph;
    logic       st;
    logic       run;
  } vec_t;

  vec_t vecs [23];

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rstN   = 1'b0;
    enable = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    // Two-phase table: legacy toggle, zero slot, gap, reset winning over enable.
    vecs[0]  = '{1'b0, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b01, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b10, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b01, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b10, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b01, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'd1, 8'd0, 2'b10, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'd0, 8'd0, 2'b01, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'd0, 8'd0, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 8'd0, 8'd0, 2'b01, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'd0, 8'd0, 2'b10, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'd2, 8'd1, 2'b00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b01, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b01, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b00, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b10, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b10, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b00, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b1, 8'd2, 8'd1, 2'b01, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 8'd2, 8'd1, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      rstN    = vecs[i].rst_n;
      enable  = vecs[i].en;
      slotLen = vecs[i].sl;
      gapLen  = vecs[i].gl;
      tick();
      chk("tbl_phase",   i, 32'(ph2),  32'(vecs[i].ph));
      chk("tbl_strobe",  i, 32'(st2),  32'(vecs[i].st));
      chk("tbl_running", i, 32'(run2), 32'(vecs[i].run));
    end

    // Four phases, L=3, G=2: 20-cycle rounds, never more than one bit high.
    do_reset();
    enable = 1'b1; slotLen = 8'd3; gapLen = 8'd2;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] exp_ph;
      int pos;
      tick();
      pos    = t % 20;
      exp_ph = ((pos % 5) < 3) ? (4'b0001 << (pos / 5)) : 4'b0000;
      chk("novl_phase",  t, 32'(ph4), 32'(exp_ph));
      chk("novl_strobe", t, 32'(st4), 32'(pos == 0));
      chk("novl_onehot", t, 32'($countones(ph4) <= 1), 32'd1);
      if (t == 4) chk("novl_run_gap", t, 32'(run4), 32'd1);
    end

    // Four phases: slotLen 2 -> 5 during phase 1 applies only from the next round.
    do_reset();
    enable = 1'b1; slotLen = 8'd2; gapLen = 8'd0;
    for (int t = 0; t < 15; t++) begin
      logic [3:0] exp_ph;
      tick();
      if (t == 2) slotLen = 8'd5;
      exp_ph = (t < 8) ? (4'b0001 << (t / 2)) : ((t < 13) ? 4'b0001 : 4'b0010);
      chk("cfg_phase",  t, 32'(ph4), 32'(exp_ph));
      chk("cfg_strobe", t, 32'(st4), 32'((t == 0) || (t == 8)));
    end

    // Three phases, L=2, G=1: enable dropped in phase 0, the round still runs 9 cycles.
    do_reset();
    enable = 1'b1; slotLen = 8'd2; gapLen = 8'd1;
    for (int t = 0; t < 12; t++) begin
      logic [2:0] exp_ph;
      tick();
      if (t == 0) enable = 1'b0;
      exp_ph = (t < 9 && (t % 3) < 2) ? (3'b001 << (t / 3)) : 3'b000;
      chk("drop_phase",   t, 32'(ph3),  32'(exp_ph));
      chk("drop_strobe",  t, 32'(st3),  32'(t == 0));
      chk("drop_running", t, 32'(run3), 32'(t < 9));
    end

    // Three phases, L=3: one reset edge in phase 2, then a clean restart.
    do_reset();
    enable = 1'b1; slotLen = 8'd3; gapLen = 8'd0;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("rst_pre_phase", t, 32'(ph3), 32'(3'b001 << (t / 3)));
    end
    rstN = 1'b0;
    tick();
    chk("rst_phase",   0, 32'(ph3),  32'd0);
    chk("rst_strobe",  0, 32'(st3),  32'd0);
    chk("rst_running", 0, 32'(run3), 32'd0);
    rstN = 1'b1;
    tick();
    chk("rst_restart_phase",   0, 32'(ph3),  32'b001);
    chk("rst_restart_strobe",  0, 32'(st3),  32'd1);
    chk("rst_restart_running", 0, 32'(run3), 32'd1);
    tick();
    chk("rst_restart_phase",  1, 32'(ph3), 32'b001);
    chk("rst_restart_strobe", 1, 32'(st3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
